soc_dma_top: RTL and testbench

Single-channel memory-to-memory DMA engine with an AXI-Lite slave register port for CPU configuration and a simplified AXI master port to system memory. The CPU programs source, destination and length, then writes START. The block copies the data one 32-bit word at a time: read one word, write it, then move to the next. It sits between the CPU configuration bus and the memory interconnect.

---
 rtl/soc_dma_top_if.sv | 61 ++++++
 rtl/soc_dma_top.sv | 168 ++++++++++++++++
 tb/tb_soc_dma_top.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_dma_top_if.sv
// Bus bundles for the DMA engine: AXI-Lite style config port and
// simplified AXI memory master port.
interface axil_cfg_if;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic [31:0] s_axi_wdata;
   logic        s_axi_wvalid;
   logic        s_axi_awready;
   logic        s_axi_wready;
   logic        s_axi_bvalid;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic        s_axi_rvalid;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
      input  s_axi_araddr, s_axi_arvalid,
      output s_axi_awready, s_axi_wready, s_axi_bvalid,
      output s_axi_arready, s_axi_rdata, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
      output s_axi_araddr, s_axi_arvalid,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid,
      input  s_axi_arready, s_axi_rdata, s_axi_rvalid
   );
endinterface

interface axi_mem_if;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic        axi_wvalid;
   logic        axi_wready;
   logic        axi_bvalid;
   logic        axi_bready;

   modport master (
      output axi_araddr, axi_arvalid, axi_rready,
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, axi_bready,
      input  axi_arready, axi_rdata, axi_rvalid,
      input  axi_awready, axi_wready, axi_bvalid
   );

   modport slave (
      input  axi_araddr, axi_arvalid, axi_rready,
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, axi_bready,
      output axi_arready, axi_rdata, axi_rvalid,
      output axi_awready, axi_wready, axi_bvalid
   );
endinterface

// File: rtl/soc_dma_top.sv
// Single-channel word-by-word memory-to-memory DMA with a small config
// register file on the slave port.
//
// state     | meaning
// ----------+---------------------------------------------
// S_IDLE    | waiting for START
// S_ZERO    | START with zero words: busy for one cycle
// S_RD_ADDR | issuing read address (current source)
// S_RD_DATA | waiting for read data into data buffer
// S_WR      | issuing write address and data
// S_WR_RESP | waiting for write response, advance pointers
module soc_dma_top (
   input  logic      clk,
   input  logic      rst_n,
   axil_cfg_if.slave cfg,
   axi_mem_if.master mem
);
   typedef enum logic [2:0] {
      S_IDLE, S_ZERO, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] src_q, dst_q, len_q;
   logic [31:0] cur_src, cur_dst, data_q, rdata_q;
   logic [29:0] cnt_q;
   logic        done_q, aw_done, w_done;
   logic        awready_q, arready_q, bvalid_q, rvalid_q;
   logic        wr_fire, rd_fire, start, busy, aw_acc, w_acc, last_word;
   logic        ar_v, r_rdy, aw_v, w_v, b_rdy;
   logic        unused_addr;

   assign busy      = (state != S_IDLE);
   assign wr_fire   = cfg.s_axi_awvalid & cfg.s_axi_wvalid & awready_q;
   assign rd_fire   = cfg.s_axi_arvalid & arready_q;
   assign start     = wr_fire & ~busy & (cfg.s_axi_awaddr[7:0] == 8'h0C) & cfg.s_axi_wdata[0];
   assign aw_acc    = (state == S_WR) & ~aw_done & mem.axi_awready;
   assign w_acc     = (state == S_WR) & ~w_done & mem.axi_wready;
   assign last_word = (cnt_q == 30'd1);
   assign unused_addr = ^{cfg.s_axi_awaddr[31:8], cfg.s_axi_araddr[31:8]};

   assign cfg.s_axi_awready = awready_q;
   assign cfg.s_axi_wready  = awready_q;
   assign cfg.s_axi_bvalid  = bvalid_q;
   assign cfg.s_axi_arready = arready_q;
   assign cfg.s_axi_rdata   = rdata_q;
   assign cfg.s_axi_rvalid  = rvalid_q;

   assign mem.axi_araddr  = cur_src;
   assign mem.axi_arvalid = ar_v;
   assign mem.axi_rready  = r_rdy;
   assign mem.axi_awaddr  = cur_dst;
   assign mem.axi_awvalid = aw_v;
   assign mem.axi_wdata   = data_q;
   assign mem.axi_wvalid  = w_v;
   assign mem.axi_bready  = b_rdy;

   // Readies are registered so they are low in reset and drop exactly in
   // the response cycle that follows an accepted transfer.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
      end else begin
         awready_q <= ~wr_fire;
         bvalid_q  <= wr_fire;
         arready_q <= ~rd_fire;
         rvalid_q  <= rd_fire;
         if (wr_fire && !busy) begin
            case (cfg.s_axi_awaddr[7:0])
               8'h00:   src_q <= cfg.s_axi_wdata;
               8'h04:   dst_q <= cfg.s_axi_wdata;
               8'h08:   len_q <= cfg.s_axi_wdata;
               default: ;
            endcase
         end
         if (rd_fire) begin
            case (cfg.s_axi_araddr[7:0])
               8'h00:   rdata_q <= src_q;
               8'h04:   rdata_q <= dst_q;
               8'h08:   rdata_q <= len_q;
               8'h10:   rdata_q <= {30'd0, done_q, busy};
               default: rdata_q <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cur_src <= '0;
         cur_dst <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (start) begin
            cur_src <= src_q;
            cur_dst <= dst_q;
            cnt_q   <= len_q[31:2];
            done_q  <= 1'b0;
         end
         if (state == S_RD_DATA && mem.axi_rvalid)
            data_q <= mem.axi_rdata;
         if (state == S_WR) begin
            if (aw_acc) aw_done <= 1'b1;
            if (w_acc)  w_done  <= 1'b1;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == S_WR_RESP && mem.axi_bvalid) begin
            cur_src <= cur_src + 32'd4;
            cur_dst <= cur_dst + 32'd4;
            cnt_q   <= cnt_q - 30'd1;
            if (last_word) done_q <= 1'b1;
         end
         if (state == S_ZERO)
            done_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ar_v      = 1'b0;
      r_rdy     = 1'b0;
      aw_v      = 1'b0;
      w_v       = 1'b0;
      b_rdy     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = (len_q[31:2] == 30'd0) ? S_ZERO : S_RD_ADDR;
         end
         S_ZERO: state_nxt = S_IDLE;
         S_RD_ADDR: begin
            ar_v = 1'b1;
            if (mem.axi_arready) state_nxt = S_RD_DATA;
         end
         S_RD_DATA: begin
            r_rdy = 1'b1;
            if (mem.axi_rvalid) state_nxt = S_WR;
         end
         S_WR: begin
            aw_v = ~aw_done;
            w_v  = ~w_done;
            if ((aw_done | aw_acc) & (w_done | w_acc)) state_nxt = S_WR_RESP;
         end
         S_WR_RESP: begin
            b_rdy = 1'b1;
            if (mem.axi_bvalid) state_nxt = last_word ? S_IDLE : S_RD_ADDR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_soc_dma_top.sv
// Bench for soc_dma_top: CPU config tasks, a small memory model with
// optional backpressure, and a scoreboard of expected reads and writes.
module tb_soc_dma_top;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   axil_cfg_if cfg_bus ();
   axi_mem_if  mem_bus ();

   soc_dma_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (cfg_bus),
      .mem   (mem_bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   logic [31:0] mem_img [64];
   logic [31:0] ref_img [64];
   logic [31:0] exp_rd_q [$];
   logic [63:0] exp_wr_q [$];
   int          ar_cyc_q [$];
   int          stall = 0;
   int          cyc = 0;
   int          ar_cnt = 0, aw_cnt = 0, wr_cnt = 0;
   int          ar_st, aw_st, w_st;
   logic        aw_pend, w_pend, ar_wait, aw_wait, w_wait;
   logic [31:0] aw_addr_p, w_data_p, prev_ar, prev_aw, prev_w;
   logic [63:0] exp_w;

   // Memory model: decisions for the upcoming rising edge are made on the
   // falling edge, while DUT outputs are stable.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         aw_pend = 0; w_pend = 0;
         ar_wait = 0; aw_wait = 0; w_wait = 0;
         ar_st = 0; aw_st = 0; w_st = 0;
      end else begin
         if (ar_wait) begin
            chk("ar_hold", mem_bus.axi_arvalid, 1);
            chk("ar_stable", mem_bus.axi_araddr, prev_ar);
         end
         if (aw_wait) begin
            chk("aw_hold", mem_bus.axi_awvalid, 1);
            chk("aw_stable", mem_bus.axi_awaddr, prev_aw);
         end
         if (w_wait) begin
            chk("w_hold", mem_bus.axi_wvalid, 1);
            chk("w_stable", mem_bus.axi_wdata, prev_w);
         end
         mem_bus.axi_arready = (stall == 0) || (mem_bus.axi_arvalid && ar_st >= stall);
         mem_bus.axi_awready = (stall == 0) || (mem_bus.axi_awvalid && aw_st >= stall);
         mem_bus.axi_wready  = (stall == 0) || (mem_bus.axi_wvalid && w_st >= stall);
         if (mem_bus.axi_arvalid && !mem_bus.axi_arready) ar_st++;
         if (mem_bus.axi_awvalid && !mem_bus.axi_awready) aw_st++;
         if (mem_bus.axi_wvalid && !mem_bus.axi_wready) w_st++;

         if (mem_bus.axi_arvalid && mem_bus.axi_arready) begin
            ar_cnt++; ar_st = 0; ar_wait = 0;
            ar_cyc_q.push_back(cyc);
            if (exp_rd_q.size() == 0) chk("rd_unexpected", exp_rd_q.size(), 1);
            else chk("rd_addr", mem_bus.axi_araddr, exp_rd_q.pop_front());
            mem_bus.axi_rdata = mem_img[mem_bus.axi_araddr[7:2]];
         end else begin
            ar_wait = mem_bus.axi_arvalid;
            prev_ar = mem_bus.axi_araddr;
         end
         if (mem_bus.axi_awvalid && mem_bus.axi_awready) begin
            aw_cnt++; aw_st = 0; aw_wait = 0;
            aw_pend = 1; aw_addr_p = mem_bus.axi_awaddr;
         end else begin
            aw_wait = mem_bus.axi_awvalid;
            prev_aw = mem_bus.axi_awaddr;
         end
         if (mem_bus.axi_wvalid && mem_bus.axi_wready) begin
            w_st = 0; w_wait = 0;
            w_pend = 1; w_data_p = mem_bus.axi_wdata;
         end else begin
            w_wait = mem_bus.axi_wvalid;
            prev_w = mem_bus.axi_wdata;
         end
         if (aw_pend && w_pend) begin
            wr_cnt++;
            mem_img[aw_addr_p[7:2]] = w_data_p;
            if (exp_wr_q.size() == 0) chk("wr_unexpected", exp_wr_q.size(), 1);
            else begin
               exp_w = exp_wr_q.pop_front();
               chk("wr_addr", aw_addr_p, exp_w[63:32]);
               chk("wr_data", w_data_p, exp_w[31:0]);
            end
            aw_pend = 0; w_pend = 0;
         end
      end
   end

   task automatic set_word(input int idx, input logic [31:0] v);
      mem_img[idx] = v;
      ref_img[idx] = v;
   endtask

   // Reference copy: strictly word by word on its own memory image.
   task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
      logic [31:0] w;
      for (int i = 0; i < int'(l >> 2); i++) begin
         exp_rd_q.push_back(s);
         w = ref_img[s[7:2]];
         exp_wr_q.push_back({d, w});
         ref_img[d[7:2]] = w;
         s = s + 32'd4;
         d = d + 32'd4;
      end
   endtask

   task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
      int k = 0;
      @(negedge clk);
      cfg_bus.s_axi_awaddr  = a;
      cfg_bus.s_axi_wdata   = d;
      cfg_bus.s_axi_awvalid = 1;
      cfg_bus.s_axi_wvalid  = 1;
      while (!(cfg_bus.s_axi_awready && cfg_bus.s_axi_wready) && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk("cfg_wr_timeout", k, 0);
      @(negedge clk);
      cfg_bus.s_axi_awvalid = 0;
      cfg_bus.s_axi_wvalid  = 0;
      chk("bvalid_hi", cfg_bus.s_axi_bvalid, 1);
      chk("awready_lo", cfg_bus.s_axi_awready, 0);
      @(negedge clk);
      chk("bvalid_lo", cfg_bus.s_axi_bvalid, 0);
   endtask

   task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
      int k = 0;
      @(negedge clk);
      cfg_bus.s_axi_araddr  = a;
      cfg_bus.s_axi_arvalid = 1;
      while (!cfg_bus.s_axi_arready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk("cfg_rd_timeout", k, 0);
      @(negedge clk);
      cfg_bus.s_axi_arvalid = 0;
      chk("rvalid", cfg_bus.s_axi_rvalid, 1);
      d = cfg_bus.s_axi_rdata;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      cfg_rd(a, v);
      chk(tag, v, exp);
   endtask

   task automatic wait_done();
      logic [31:0] st = 0;
      for (int i = 0; i < 300; i++) begin
         cfg_rd(32'h10, st);
         if (st == 32'h2) break;
      end
      chk("status_done", st, 32'h2);
   endtask

   int a0, w0, base;

   initial begin
      cfg_bus.s_axi_awaddr = 0; cfg_bus.s_axi_awvalid = 0;
      cfg_bus.s_axi_wdata  = 0; cfg_bus.s_axi_wvalid  = 0;
      cfg_bus.s_axi_araddr = 0; cfg_bus.s_axi_arvalid = 0;
      mem_bus.axi_arready = 1; mem_bus.axi_awready = 1; mem_bus.axi_wready = 1;
      mem_bus.axi_rvalid  = 1; mem_bus.axi_bvalid  = 1; mem_bus.axi_rdata  = 0;
      for (int i = 0; i < 64; i++) set_word(i, 32'h0);

      // reset then idle
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("rst_awready", cfg_bus.s_axi_awready, 0);
      chk("rst_arready", cfg_bus.s_axi_arready, 0);
      chk("rst_bvalid", cfg_bus.s_axi_bvalid, 0);
      rst_n = 0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_arvalid", mem_bus.axi_arvalid, 0);
         chk("idle_awvalid", mem_bus.axi_awvalid, 0);
         chk("idle_wvalid", mem_bus.axi_wvalid, 0);
      end
      rd_chk("rst_status", 32'h10, 0);
      rd_chk("rst_src", 32'h00, 0);
      rd_chk("rst_dst", 32'h04, 0);
      rd_chk("rst_len", 32'h08, 0);

      // register write / readback, unmapped access
      cfg_wr(32'h00, 32'h100);
      cfg_wr(32'h04, 32'h200);
      cfg_wr(32'h08, 32'h10);
      cfg_wr(32'h14, 32'hFFFF_FFFF);
      rd_chk("rb_src", 32'h00, 32'h100);
      rd_chk("rb_dst", 32'h04, 32'h200);
      rd_chk("rb_len", 32'h08, 32'h10);
      rd_chk("rb_unmapped", 32'h14, 0);
      rd_chk("rb_ctrl", 32'h0C, 0);
      chk("rb_no_traffic", ar_cnt + aw_cnt, 0);

      // two-word overlapping copy
      set_word(0, 32'hDEADBEEF);
      set_word(1, 32'hBAADF00D);
      cfg_wr(32'h00, 32'h0);
      cfg_wr(32'h04, 32'h4);
      cfg_wr(32'h08, 32'h8);
      model_copy(32'h0, 32'h4, 32'h8);
      base = wr_cnt;
      ar_cyc_q.delete();
      cfg_wr(32'h0C, 32'h1);
      wait_done();
      chk("copy2_writes", wr_cnt - base, 2);
      chk("copy2_rd_left", exp_rd_q.size(), 0);
      chk("copy2_wr_left", exp_wr_q.size(), 0);
      chk("copy2_word2", mem_img[2], 32'hDEADBEEF);
      if (ar_cyc_q.size() >= 2) chk("word_period", ar_cyc_q[1] - ar_cyc_q[0], 4);
      else chk("word_period_reads", ar_cyc_q.size(), 2);

      // zero-word starts: LEN=0 and LEN=3
      for (int l = 0; l < 4; l += 3) begin
         a0 = ar_cnt; w0 = aw_cnt;
         cfg_wr(32'h08, l);
         cfg_wr(32'h0C, 32'h1);
         rd_chk("zero_status", 32'h10, 32'h2);
         chk("zero_no_rd", ar_cnt - a0, 0);
         chk("zero_no_wr", aw_cnt - w0, 0);
      end

      // busy protection during a four-word copy
      for (int i = 0; i < 4; i++) set_word(16 + i, 32'h1111_0000 + i);
      cfg_wr(32'h00, 32'h40);
      cfg_wr(32'h04, 32'h80);
      cfg_wr(32'h08, 32'h10);
      model_copy(32'h40, 32'h80, 32'h10);
      base = wr_cnt; a0 = ar_cnt;
      cfg_wr(32'h0C, 32'h1);
      cfg_wr(32'h00, 32'h300);
      cfg_wr(32'h0C, 32'h1);
      rd_chk("busy_src_kept", 32'h00, 32'h40);
      wait_done();
      repeat (5) @(negedge clk);
      chk("busy_writes", wr_cnt - base, 4);
      chk("busy_reads", ar_cnt - a0, 4);
      chk("busy_wr_left", exp_wr_q.size(), 0);

      // backpressure on arready/awready/wready
      set_word(40, 32'hCAFE_0001);
      set_word(41, 32'hCAFE_0002);
      stall = 3;
      cfg_wr(32'h00, 32'hA0);
      cfg_wr(32'h04, 32'hC0);
      cfg_wr(32'h08, 32'h8);
      model_copy(32'hA0, 32'hC0, 32'h8);
      base = wr_cnt;
      cfg_wr(32'h0C, 32'h1);
      wait_done();
      stall = 0;
      chk("bp_writes", wr_cnt - base, 2);
      chk("bp_wr_left", exp_wr_q.size(), 0);
      chk("bp_word0", mem_img[48], 32'hCAFE_0001);
      chk("bp_word1", mem_img[49], 32'hCAFE_0002);

      // reset mid-transfer aborts all master activity
      cfg_wr(32'h00, 32'h0);
      cfg_wr(32'h04, 32'hE0);
      cfg_wr(32'h08, 32'h10);
      model_copy(32'h0, 32'hE0, 32'h10);
      cfg_wr(32'h0C, 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      rst_n = 0;
      exp_rd_q.delete();
      exp_wr_q.delete();
      a0 = ar_cnt; w0 = aw_cnt;
      repeat (6) begin
         @(negedge clk);
         chk("abort_arvalid", mem_bus.axi_arvalid, 0);
         chk("abort_awvalid", mem_bus.axi_awvalid, 0);
      end
      chk("abort_no_rd", ar_cnt - a0, 0);
      chk("abort_no_wr", aw_cnt - w0, 0);
      rd_chk("abort_status", 32'h10, 0);
      rd_chk("abort_src", 32'h00, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: time=%0t limit=500000", $time);
      $fatal(1, "bench did not finish in time");
   end
endmodule
